cnt_diff_monitor: RTL and testbench

Checker block that sits on the compare side of the dual 32-bit counter design. It samples the two counter values each clock, classifies the relationship as matching, diverging, or locked at a constant offset, and emits divergence/convergence events. It also keeps saturating mismatch statistics, so benches and on-chip debug can see how and when the counters separated.

---
 rtl/cnt_diff_monitor.sv | 114 +++++++++++
 tb/tb_cnt_diff_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cnt_diff_monitor.sv
// Compares two counters each cycle and classifies them as MATCH, DIVERGE or LOCK at a constant offset.
// 1-cycle latency with all outputs registered; no backpressure, so one sample is taken every clock.
module cnt_diff_monitor #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] cnt_a,
    input  logic [WIDTH-1:0] cnt_b,
    output logic             mismatch,
    output logic [WIDTH-1:0] offset,
    output logic [1:0]       state,
    output logic             offset_locked,
    output logic             diverge_evt,
    output logic             converge_evt,
    output logic             first_valid,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH-1:0] mismatch_cycles,
    output logic [15:0]      episodes
);

    typedef enum logic [1:0] {
        MATCH   = 2'b00,
        DIVERGE = 2'b01,
        LOCK    = 2'b10
    } state_t;

    localparam logic [7:0] SETTLE_W = 8'(SETTLE);

    state_t           st;
    logic [7:0]       stable;
    logic             eq;
    logic [WIDTH-1:0] d;

    assign eq    = (cnt_a == cnt_b);
    assign d     = cnt_a - cnt_b;
    assign state = st;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            st              <= MATCH;
            stable          <= 8'd0;
            mismatch        <= 1'b0;
            offset          <= '0;
            offset_locked   <= 1'b0;
            diverge_evt     <= 1'b0;
            converge_evt    <= 1'b0;
            first_valid     <= 1'b0;
            first_a         <= '0;
            first_b         <= '0;
            mismatch_cycles <= '0;
            episodes        <= 16'd0;
        end else begin
            mismatch     <= !eq;
            offset       <= d;
            diverge_evt  <= 1'b0;
            converge_evt <= 1'b0;
            if (!eq && (mismatch_cycles != '1))
                mismatch_cycles <= mismatch_cycles + WIDTH'(1);

            case (st)
                MATCH: begin
                    if (!eq) begin
                        st          <= DIVERGE;
                        diverge_evt <= 1'b1;
                        stable      <= 8'd0;
                        if (episodes != 16'hFFFF)
                            episodes <= episodes + 16'd1;
                        if (!first_valid) begin
                            first_valid <= 1'b1;
                            first_a     <= cnt_a;
                            first_b     <= cnt_b;
                        end
                    end
                end
                DIVERGE: begin
                    if (eq) begin
                        st           <= MATCH;
                        converge_evt <= 1'b1;
                    end else if (d == offset) begin
                        // Lock is declared on the sample that brings the run up to SETTLE.
                        stable <= stable + 8'd1;
                        if (stable + 8'd1 == SETTLE_W) begin
                            st            <= LOCK;
                            offset_locked <= 1'b1;
                        end
                    end else begin
                        stable <= 8'd0;
                    end
                end
                LOCK: begin
                    if (eq) begin
                        st            <= MATCH;
                        converge_evt  <= 1'b1;
                        offset_locked <= 1'b0;
                    end else if (d != offset) begin
                        // Losing lock is not a new episode.
                        st            <= DIVERGE;
                        stable        <= 8'd0;
                        offset_locked <= 1'b0;
                    end
                end
                default: begin
                    st            <= MATCH;
                    offset_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_diff_monitor.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_cnt_diff_monitor;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [31:0] cnt_a, cnt_b;
    logic [7:0]  a8, b8;

    logic        mismatch, offset_locked, diverge_evt, converge_evt, first_valid;
    logic [31:0] offset, first_a, first_b, mismatch_cycles;
    logic [1:0]  state;
    logic [15:0] episodes;

    logic        mismatch8, offset_locked8, diverge_evt8, converge_evt8, first_valid8;
    logic [7:0]  offset8, first_a8, first_b8, mismatch_cycles8;
    logic [1:0]  state8;
    logic [15:0] episodes8;

    always #5 clk = ~clk;

    cnt_diff_monitor #(.WIDTH(32), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .mismatch(mismatch), .offset(offset), .state(state),
        .offset_locked(offset_locked), .diverge_evt(diverge_evt),
        .converge_evt(converge_evt), .first_valid(first_valid),
        .first_a(first_a), .first_b(first_b),
        .mismatch_cycles(mismatch_cycles), .episodes(episodes)
    );

    cnt_diff_monitor #(.WIDTH(8), .SETTLE(SETTLE)) u_dut8 (
        .clk(clk), .rst(rst), .clr(clr), .cnt_a(a8), .cnt_b(b8),
        .mismatch(mismatch8), .offset(offset8), .state(state8),
        .offset_locked(offset_locked8), .diverge_evt(diverge_evt8),
        .converge_evt(converge_evt8), .first_valid(first_valid8),
        .first_a(first_a8), .first_b(first_b8),
        .mismatch_cycles(mismatch_cycles8), .episodes(episodes8)
    );

    typedef struct {
        logic        mm;
        logic [31:0] off;
        logic [1:0]  st;
        logic        lk, dv, cv, fv;
        logic [31:0] fa, fb, mc;
        logic [15:0] ep;
        logic [7:0]  mc8;
        logic        mm8;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: episode-level view with a run length of repeated offsets.
    bit          m_in_ep;
    int          m_run;
    logic [31:0] m_prev_d;
    bit          m_fv;
    logic [31:0] m_fa, m_fb;
    longint      m_mc;
    int          m_ep;
    int          m_mc8;

    task automatic model(input logic r, input logic c, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] x8, input logic [7:0] y8, output exp_t e);
        logic [31:0] d;
        e = '{mm: 0, off: 0, st: 0, lk: 0, dv: 0, cv: 0, fv: 0, fa: 0, fb: 0, mc: 0, ep: 0, mc8: 0, mm8: 0};
        if (r || c) begin
            m_in_ep = 0; m_run = 0; m_prev_d = 0; m_fv = 0; m_fa = 0; m_fb = 0;
            m_mc = 0; m_ep = 0; m_mc8 = 0;
            return;
        end
        d = a - b;
        if (a != b) begin
            if (!m_in_ep) begin
                m_in_ep = 1; e.dv = 1; m_run = 0;
                if (m_ep < 65535) m_ep++;
                if (!m_fv) begin m_fv = 1; m_fa = a; m_fb = b; end
            end else begin
                m_run = (d == m_prev_d) ? m_run + 1 : 0;
            end
            if (m_mc < 64'hFFFF_FFFF) m_mc++;
        end else begin
            if (m_in_ep) e.cv = 1;
            m_in_ep = 0; m_run = 0;
        end
        if (x8 != y8 && m_mc8 < 255) m_mc8++;
        m_prev_d = d;
        e.mm  = (a != b);
        e.off = d;
        e.st  = !m_in_ep ? 2'b00 : (m_run >= SETTLE ? 2'b10 : 2'b01);
        e.lk  = (e.st == 2'b10);
        e.fv  = m_fv; e.fa = m_fa; e.fb = m_fb;
        e.mc  = m_mc[31:0];
        e.ep  = m_ep[15:0];
        e.mc8 = m_mc8[7:0];
        e.mm8 = (x8 != y8);
    endtask

    task automatic step(input logic r, input logic c, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] x8, input logic [7:0] y8);
        exp_t e;
        rst = r; clr = c; cnt_a = a; cnt_b = b; a8 = x8; b8 = y8;
        model(r, c, a, b, x8, y8, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mismatch",        32'(mismatch),      32'(e.mm));
                chk("offset",          offset,             e.off);
                chk("state",           32'(state),         32'(e.st));
                chk("offset_locked",   32'(offset_locked), 32'(e.lk));
                chk("diverge_evt",     32'(diverge_evt),   32'(e.dv));
                chk("converge_evt",    32'(converge_evt),  32'(e.cv));
                chk("first_valid",     32'(first_valid),   32'(e.fv));
                chk("first_a",         first_a,            e.fa);
                chk("first_b",         first_b,            e.fb);
                chk("mismatch_cycles", mismatch_cycles,    e.mc);
                chk("episodes",        32'(episodes),      32'(e.ep));
                chk("mismatch_cycles8", 32'(mismatch_cycles8), 32'(e.mc8));
                chk("mismatch8",       32'(mismatch8),     32'(e.mm8));
            end
        end
    end

    initial begin
        logic [31:0] x, off, b;
        logic [7:0]  r8;
        int          sel;
        rst = 1; clr = 0; cnt_a = 0; cnt_b = 0; a8 = 0; b8 = 0;
        @(negedge clk);
        step(1, 0, 32'd5, 32'd9, 8'd1, 8'd2);
        step(1, 0, 32'd0, 32'd0, 8'd0, 8'd0);

        // Lockstep counting.
        for (int i = 0; i < 100; i++) step(0, 0, i, i, 8'(i), 8'(i));

        // Single counter reset, then both increment: offset 0xFFFF_FFF5 locks.
        for (int i = 0; i < 10; i++) step(0, 0, i, i + 11, 8'd0, 8'd0);
        // Re-converge.
        for (int i = 0; i < 4; i++) step(0, 0, 50 + i, 50 + i, 8'd0, 8'd0);
        // Diverge, lock, one-cycle jitter, relock.
        for (int i = 0; i < 7; i++) step(0, 0, 100 + i, 90 + i, 8'd0, 8'd0);
        step(0, 0, 107, 96, 8'd0, 8'd0);
        for (int i = 8; i < 16; i++) step(0, 0, 100 + i, 90 + i, 8'd0, 8'd0);
        // Clear mid-lock with counters still apart.
        step(0, 1, 116, 106, 8'd0, 8'd0);
        for (int i = 17; i < 24; i++) step(0, 0, 100 + i, 90 + i, 8'd0, 8'd0);
        // Single-cycle glitch.
        step(0, 0, 200, 200, 8'd0, 8'd0);
        step(0, 0, 201, 7, 8'd0, 8'd0);
        step(0, 0, 202, 202, 8'd0, 8'd0);

        // Randomized phase.
        x = $urandom; off = 0;
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 99);
            r8  = 8'($urandom);
            if (sel < 3) begin
                step(0, 1, x, x - off, r8, r8 ^ 8'($urandom));
            end else if (sel < 5) begin
                step(1, 0, x, x - off, r8, r8);
            end else begin
                if (sel < 12) off = 0;
                else if (sel < 20) off = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(1, 20);
                b = x - off;
                if (sel >= 20 && sel < 25) b = b + 1;
                step(0, 0, x, b, r8, ($urandom_range(0, 3) == 0) ? r8 : 8'($urandom));
            end
            x = x + $urandom_range(0, 2);
        end

        // Narrow build: hold an 8-bit mismatch long enough to saturate.
        step(0, 1, 0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 270; i++) step(0, 0, i, i, 8'(i), 8'(i + 3));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain: %0d expected samples never compared", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
